// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit with redirect handling and a one-entry decode buffer.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (align redirect targets and flag misalignment).
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic        misalign_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
    state_t      r_state, w_next;
    logic [31:0] r_pc, r_id_instr, r_id_pc, w_redir_pc;
    logic        r_id_valid, w_slot_free, w_req, w_load;
    assign w_slot_free = ~r_id_valid | id_ready;
    assign w_load      = (r_state == WAIT) & imem_rvalid & ~redirect_valid;
    assign imem_req    = w_req;
    assign imem_addr   = r_pc;
    assign id_valid    = r_id_valid;
    assign id_instr    = r_id_instr;
    assign id_pc       = r_id_pc;
    assign id_pc4      = r_id_pc + 32'd4;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_misalign;
    assign w_redir_pc   = {redirect_pc[31:2], 2'b00};
    assign misalign_err = r_misalign;
    // One-cycle pulse after any redirect whose target is not word aligned
    always_ff @(posedge clk) begin
        if (!rstn) r_misalign <= 1'b0;
        else r_misalign <= redirect_valid & (redirect_pc[1:0] != 2'b00);
    end
`else
    assign w_redir_pc   = redirect_pc;
    assign misalign_err = 1'b0;
`endif
    // Next-state and request logic; a response always ends WAIT/DROP even alongside a redirect
    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        case (r_state)
            IDLE: w_next = REQ;
            REQ: begin
                w_req  = rstn & w_slot_free & ~redirect_valid;
                w_next = (w_req & imem_ready) ? WAIT : REQ;
            end
            WAIT: w_next = imem_rvalid ? REQ : (redirect_valid ? DROP : WAIT);
            DROP: w_next = imem_rvalid ? REQ : DROP;
        endcase
    end
    // State, PC and decode buffer; redirect overrides both PC advance and buffer contents
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_pc       <= RESET_PC;
            r_id_valid <= 1'b0;
            r_id_instr <= 32'h0000_0013;
            r_id_pc    <= RESET_PC;
        end else begin
            r_state    <= w_next;
            r_pc       <= redirect_valid ? w_redir_pc : (w_load ? r_pc + 32'd4 : r_pc);
            r_id_valid <= ~redirect_valid & (w_load | (r_id_valid & ~id_ready));
            if (w_load) begin
                r_id_instr <= imem_rdata;
                r_id_pc    <= r_pc;
            end
        end
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk  in  1  system clock; the only clock, all state updates on rising edge.
REQ-003 SHALL have port rstn  in  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-004 SHALL have port imem_req  out  1  fetch request valid.
REQ-005 SHALL have port imem_addr  out  32  fetch byte address (current PC).
REQ-006 SHALL have port imem_ready  in  1  memory accepts the request this cycle.
REQ-007 SHALL have port imem_rvalid  in  1  response data valid.
REQ-008 SHALL have port imem_rdata  in  32  fetched instruction word.
REQ-009 SHALL have port redirect_valid  in  1  branch/jump redirect strobe.
REQ-010 SHALL have port redirect_pc  in  32  redirect target address.
REQ-011 SHALL have port id_valid  out  1  id_instr/id_pc hold a valid instruction for the decode/immediate stage.
REQ-012 SHALL have port id_ready  in  1  decode stage consumes the instruction this cycle.
REQ-013 SHALL have port id_instr  out  32  instruction word to decoder and immediate extractor.
REQ-014 SHALL have port id_pc  out  32  address of id_instr.
REQ-015 SHALL have port id_pc4  out  32  id_pc + 4, modulo 2^32.
REQ-016 SHALL have port misalign_err  out  1  misaligned redirect pulse (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, REQ, WAIT, DROP.
REQ-018 IDLE: imem_req=0; next state REQ unconditionally.
REQ-019 REQ: imem_req = slot_free & ~redirect_valid, where slot_free = ~id_valid | id_ready; imem_addr = pc.
REQ-020 REQ: on imem_req & imem_ready, go to WAIT; otherwise stay in REQ.
REQ-021 WAIT: on imem_rvalid, load id_instr<=imem_rdata, id_pc<=pc, set id_valid=1, pc<=pc+4, go to REQ.
REQ-022 At most one request SHALL be outstanding; no request is issued in WAIT or DROP.
REQ-023 id_valid SHALL clear when id_valid & id_ready and no new instruction loads that cycle; id_instr/id_pc SHALL hold while id_valid & ~id_ready.
REQ-024 Redirect has highest priority in every state: pc<=redirect_pc, id_valid<=0.
REQ-025 Redirect in REQ: no request issued that cycle; stay in REQ with the new PC.
REQ-026 Redirect in WAIT without rvalid: go to DROP. With rvalid the same cycle: discard data, go to REQ.
REQ-027 DROP: discard the next imem_rvalid, then go to REQ; a further redirect in DROP updates pc and stays in DROP.
REQ-028 imem_rvalid SHALL be ignored in IDLE and REQ.
REQ-029 pc+4 SHALL wrap: 32'hFFFF_FFFC -> 32'h0000_0000; id_pc4 likewise.
REQ-030 Best-case throughput: one instruction per 2 cycles with imem_ready=1, 1-cycle rvalid and id_ready=1.

Reset
REQ-031 On rstn=0 at a clock edge: state=IDLE, pc=RESET_PC, id_valid=0, id_instr=32'h0000_0013 (NOP), id_pc=RESET_PC, misalign_err=0.
REQ-032 Reset mid-WAIT SHALL abandon the outstanding request; its late response is ignored per REQ-028.
REQ-033 imem_req SHALL be 0 while rstn=0 and in the first cycle after release.

Configuration
REQ-034 Macro FETCH_MISALIGN_CHECK_EN, defined: a redirect with redirect_pc[1:0]!=0 loads pc={redirect_pc[31:2],2'b00} and pulses misalign_err=1 for exactly the cycle after the redirect.
REQ-035 FETCH_MISALIGN_CHECK_EN undefined: misalign_err is tied 0 and redirect_pc is loaded unmodified.

Verification
REQ-036 Reset release, imem_ready=1, rvalid 1 cycle after acceptance, id_ready=1 -> imem_addr 0x0, 0x4, 0x8 on successive requests; id_pc matches each address; id_pc4=id_pc+4.
REQ-037 id_ready=0 for 5 cycles with id_valid=1 -> id_instr/id_pc stable, imem_req=0; first cycle id_ready=1 -> imem_req=1 with the next PC.
REQ-038 Redirect to 0x100 while in WAIT, rvalid 3 cycles later with 0xDEADBEEF -> 0xDEADBEEF never appears with id_valid=1; the next request goes to 0x100.
REQ-039 pc=0xFFFF_FFFC fetched -> id_pc4=0x0; the next imem_addr is 0x0.
REQ-040 With FETCH_MISALIGN_CHECK_EN, redirect to 0x102 -> misalign_err one-cycle pulse; the next imem_addr is 0x100. Without the macro -> misalign_err stays 0 and imem_addr is 0x102.
